// File: rtl/uart_receiver.sv
// uart_receiver: oversampling serial-to-parallel receive stage.
// Frame: idle-high line, one start bit (0), DATA_BITS data bits LSB first,
// one stop bit (1), SAMPLES_PER_BIT clocks per bit. The start bit is confirmed
// at its midpoint, after which every sample is taken one full bit later so it
// lands mid-bit. A good stop bit publishes the character; a bad one reports a
// framing error and waits for the line to return high before re-arming.
module uart_receiver #(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int DATA_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 receive_enable,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 character_received,
  output logic                 framing_error,
  output logic                 rx_busy
);

  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(SAMPLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [CW-1:0]        r_sample_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_char_rcvd;
  logic                 r_framing_err;
  logic                 w_s_in;

  assign w_s_in             = r_sync2;
  assign data_out           = r_data_out;
  assign character_received = r_char_rcvd;
  assign framing_error      = r_framing_err;
  assign rx_busy            = (r_state != IDLE);

  // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM: start validation, mid-bit sampling, stop check, one-clock result pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_sample_cnt  <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data_out    <= '0;
      r_char_rcvd   <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_char_rcvd   <= 1'b0;
      r_framing_err <= 1'b0;
      if (!receive_enable && r_state != IDLE) begin
        // Abort: drop the partial frame, keep the last good character.
        r_state      <= IDLE;
        r_sample_cnt <= '0;
        r_bit_cnt    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (receive_enable && !w_s_in) begin
              r_state      <= START;
              r_sample_cnt <= '0;
            end
          end
          START: begin
            if (r_sample_cnt == HALF_LAST) begin
              r_sample_cnt <= '0;
              r_bit_cnt    <= '0;
              // A line that is high again at mid-start was only a glitch.
              r_state      <= w_s_in ? IDLE : DATA;
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end
          DATA: begin
            if (r_sample_cnt == FULL_LAST) begin
              r_shift      <= {w_s_in, r_shift[DATA_BITS-1:1]};
              r_sample_cnt <= '0;
              r_bit_cnt    <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= STOP;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end
          STOP: begin
            if (r_sample_cnt == FULL_LAST) begin
              r_sample_cnt <= '0;
              if (w_s_in) begin
                r_data_out  <= r_shift;
                r_char_rcvd <= 1'b1;
                r_state     <= IDLE;
              end else begin
                r_framing_err <= 1'b1;
                r_state       <= WAIT_IDLE;
              end
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end
          WAIT_IDLE: begin
            // A line held low after a bad stop bit must not look like a new start.
            if (w_s_in) begin
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: frame-level reference model. Each transmitted frame
// schedules its outcome (character or framing error) at fall-edge + latency;
// a per-cycle compare process checks the DUT pulses and data_out against that
// schedule, and directed tests pin exact timing and values with literals.
module tb_uart_receiver;
  localparam int SPB = 16;
  localparam int LAT = 3 + SPB / 2 + 9 * SPB;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       receive_enable;
  logic [7:0] data_out;
  logic       character_received;
  logic       framing_error;
  logic       rx_busy;

  uart_receiver #(.SAMPLES_PER_BIT(SPB), .DATA_BITS(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .serial_in          (serial_in),
    .receive_enable     (receive_enable),
    .data_out           (data_out),
    .character_received (character_received),
    .framing_error      (framing_error),
    .rx_busy            (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int last_fall = 0;

  logic [7:0] exp_char [int];
  bit         exp_ferr [int];
  logic [7:0] model_data = 8'h00;

  int         ptime [$];
  logic [7:0] pdata [$];
  int         ftime [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the scheduled frame outcomes.
  always @(negedge clk) begin
    logic exp_c;
    logic exp_f;
    if (chk_en) begin
      exp_c = exp_char.exists(cyc);
      exp_f = exp_ferr.exists(cyc);
      chk("character_received", {31'd0, character_received}, {31'd0, exp_c});
      chk("framing_error", {31'd0, framing_error}, {31'd0, exp_f});
      if (exp_c) model_data = exp_char[cyc];
      chk("data_out", {24'd0, data_out}, {24'd0, model_data});
    end
  end

  // Record every pulse so directed tests can pin exact times and counts.
  always @(negedge clk) begin
    if (chk_en && character_received) begin
      ptime.push_back(cyc);
      pdata.push_back(data_out);
    end
    if (chk_en && framing_error) ftime.push_back(cyc);
  end

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (SPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic clear_log();
    ptime.delete();
    pdata.delete();
    ftime.delete();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    int f;
    f = cyc;
    last_fall = f;
    if (stop) exp_char[f + LAT] = d;
    else      exp_ferr[f + LAT] = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  // Start bit plus the first nbits data bits; the frame is never completed.
  task automatic drive_partial(input logic [7:0] d, input int nbits);
    last_fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
  endtask

  task automatic glitch(input int len);
    int g;
    g = cyc;
    serial_in = 1'b0;
    repeat (len) @(posedge clk);
    #1;
    serial_in = 1'b1;
    wait_neg(g + 10);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
    wait_neg(g + 11);
    chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
    @(posedge clk);
    #1;
    idle(4);
  endtask

  task automatic frame_err(input logic [7:0] d, input int extra);
    int h;
    send_frame(d, 1'b0);
    serial_in = 1'b0;
    repeat (extra) @(posedge clk);
    #1;
    h = cyc;
    serial_in = 1'b1;
    wait_neg(h + 2);
    chk("wait_idle_busy", {31'd0, rx_busy}, 32'd1);
    wait_neg(h + 3);
    chk("wait_idle_exit", {31'd0, rx_busy}, 32'd0);
    @(posedge clk);
    #1;
    idle(1);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b0;
    serial_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_char", {31'd0, character_received}, 32'd0);
    chk("rst_ferr", {31'd0, framing_error}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_char.delete();
    exp_ferr.delete();
    model_data = 8'h00;
    chk_en = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got cyc %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f1;
    int kind;
    rst = 1'b0;
    serial_in = 1'b1;
    receive_enable = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    receive_enable = 1'b1;
    idle(5);

    // 1) 0x9B, pulse exactly 155 clocks after the fall.
    clear_log();
    send_frame(8'h9B, 1'b1);
    chk("t1_pulse_count", ptime.size(), 32'd1);
    if (ptime.size() >= 1) begin
      chk("t1_latency", ptime[0] - last_fall, 32'd155);
      chk("t1_data", {24'd0, pdata[0]}, 32'h9B);
    end

    // 2) back-to-back 0x00 then 0xFF.
    clear_log();
    f1 = cyc;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(3);
    chk("t2_pulse_count", ptime.size(), 32'd2);
    if (ptime.size() >= 2) begin
      chk("t2_first_time", ptime[0] - f1, 32'd155);
      chk("t2_spacing", ptime[1] - ptime[0], 32'd160);
      chk("t2_data0", {24'd0, pdata[0]}, 32'h00);
      chk("t2_data1", {24'd0, pdata[1]}, 32'hFF);
    end

    // 3) 4-clock glitch on idle line.
    clear_log();
    glitch(4);
    chk("t3_no_pulse", ptime.size(), 32'd0);
    chk("t3_data_held", {24'd0, data_out}, 32'hFF);

    // 4) 0x55 with bad stop bit, line held low 40 more clocks.
    clear_log();
    frame_err(8'h55, 40);
    chk("t4_ferr_count", ftime.size(), 32'd1);
    if (ftime.size() >= 1) chk("t4_ferr_time", ftime[0] - last_fall, 32'd155);
    chk("t4_no_char", ptime.size(), 32'd0);
    chk("t4_data_held", {24'd0, data_out}, 32'hFF);

    // 5) drop enable at bit 4, then receive 0xA5.
    clear_log();
    drive_partial(8'hC3, 4);
    f1 = last_fall;
    receive_enable = 1'b0;
    serial_in = 1'b1;
    wait_neg(f1 + 80);
    chk("t5_busy_before", {31'd0, rx_busy}, 32'd1);
    wait_neg(f1 + 81);
    chk("t5_idle_after", {31'd0, rx_busy}, 32'd0);
    @(posedge clk);
    #1;
    idle(20);
    receive_enable = 1'b1;
    idle(5);
    send_frame(8'hA5, 1'b1);
    chk("t5_pulse_count", ptime.size(), 32'd1);
    if (ptime.size() >= 1) chk("t5_data", {24'd0, pdata[0]}, 32'hA5);

    // 6) reset mid-frame, then 0x3C.
    clear_log();
    drive_partial(8'h11, 3);
    do_reset();
    idle(5);
    send_frame(8'h3C, 1'b1);
    chk("t6_pulse_count", ptime.size(), 32'd1);
    if (ptime.size() >= 1) chk("t6_data", {24'd0, pdata[0]}, 32'h3C);
    idle(3);

    // Randomized mix of frames, gaps, glitches and framing errors.
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6) begin
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 10));
      end else if (kind <= 8) begin
        glitch($urandom_range(1, 6));
      end else begin
        frame_err(8'($urandom_range(0, 255)), $urandom_range(5, 30));
      end
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
